// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg -- state encoding and helpers shared by the bus controller.
//   bus_state_t : controller FSM states
//   idx_width() : bits needed to index N caches (never below 1)
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    SNOOP  = 3'd2,
    SNRESP = 3'd3,
    C2C    = 3'd4,
    RAMRD  = 3'd5,
    RAMWR  = 3'd6,
    IFETCH = 3'd7
  } bus_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU/memory types.
//   word_t     : 32-bit bus word (addresses, load and store data)
//   ramstate_t : memory handshake state reported by the RAM model/controller
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/bus_rr_arb.sv
// bus_rr_arb -- combinational round-robin picker.
// The search starts one slot after ptr (the last winner) and wraps.
//   req   in  N   request vector
//   ptr   in  IW  index of the previous winner
//   gnt   out N   one-hot grant
//   idx   out IW  index of the granted requester
//   valid out 1   any request present
module bus_rr_arb
  import bus_ctrl_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Walk the N slots from ptr+1 and keep the first requester found.
  always_comb begin
    int cand;
    cand  = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + 1 + i) % N;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = IW'(cand);
        gnt[cand] = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/multi_bus_ctrl.sv
// multi_bus_ctrl -- arbitrates CPUS instruction/data cache pairs onto one RAM port.
// Optional cache-to-cache coherence path compiled in with MULTI_BUS_COHERENCE_EN.
// Ports:
//   CLK, RST                               clock, async active-high reset
//   iREN, dREN, dWEN, ccwrite, cctrans     per-cache requests / coherence flags
//   iaddr, daddr, dstore                   per-cache addresses and store data
//   iwait, dwait, ccwait, ccinv            per-cache stall / snoop controls
//   iload, dload, ccsnoopaddr              per-cache return data / snoop address
//   ramREN, ramWEN, ramaddr, ramstore      RAM request side
//   ramload, ramstate                      RAM response side
module multi_bus_ctrl
  import cpu_types_pkg::*;
  import bus_ctrl_pkg::*;
#(
  parameter int CPUS       = 2,
  parameter int IPRIO_LAST = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CPUS-1:0] iREN,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  logic [CPUS-1:0] ccwrite,
  input  logic [CPUS-1:0] cctrans,
  input  word_t           iaddr [CPUS],
  input  word_t           daddr [CPUS],
  input  word_t           dstore [CPUS],
  output logic [CPUS-1:0] iwait,
  output logic [CPUS-1:0] dwait,
  output logic [CPUS-1:0] ccwait,
  output logic [CPUS-1:0] ccinv,
  output word_t           iload [CPUS],
  output word_t           dload [CPUS],
  output word_t           ccsnoopaddr [CPUS],
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  localparam int IW = idx_width(CPUS);

  bus_state_t      state_r, state_s;
  logic [IW-1:0]   grant_r, grant_s;
  logic [IW-1:0]   dptr_r, dptr_s;
  logic [IW-1:0]   iptr_r, iptr_s;
  logic [CPUS-1:0] dreq_s;
  logic [CPUS-1:0] dgnt_unused, igtn_unused;
  logic [IW-1:0]   didx_s, iidx_s;
  logic            dvalid_s, ivalid_s, pick_data_s;
  logic            alive_s, acc_s;

  assign dreq_s      = dREN | dWEN;
  assign pick_data_s = dvalid_s && ((IPRIO_LAST != 0) || !ivalid_s);

  bus_rr_arb #(.N(CPUS)) u_darb (
    .req(dreq_s), .ptr(dptr_r), .gnt(dgnt_unused), .idx(didx_s), .valid(dvalid_s)
  );

  bus_rr_arb #(.N(CPUS)) u_iarb (
    .req(iREN), .ptr(iptr_r), .gnt(igtn_unused), .idx(iidx_s), .valid(ivalid_s)
  );

`ifdef MULTI_BUS_COHERENCE_EN
  logic [IW-1:0] sup_r, sup_s, sup_idx_s;
  logic          sup_valid_s;

  // Lowest-numbered other cache currently holding a dirty write to supply data.
  always_comb begin
    sup_valid_s = 1'b0;
    sup_idx_s   = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if ((k != int'(grant_r)) && dWEN[k]) begin
        sup_valid_s = 1'b1;
        sup_idx_s   = IW'(k);
      end else begin
        sup_valid_s = sup_valid_s;
      end
    end
  end

  // Supplier index register, captured when leaving SNRESP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sup_r <= '0;
    else     sup_r <= sup_s;
  end
`else
  logic cc_unused;
  assign cc_unused = ^{ccwrite, cctrans};
`endif

  // The granted request must still be held; a dropped request aborts the transfer.
  always_comb begin
    case (state_r)
      RAMRD:   alive_s = dREN[grant_r];
      RAMWR:   alive_s = dWEN[grant_r];
      IFETCH:  alive_s = iREN[grant_r];
`ifdef MULTI_BUS_COHERENCE_EN
      SNOOP:   alive_s = dREN[grant_r];
      SNRESP:  alive_s = dREN[grant_r];
      C2C:     alive_s = dREN[grant_r] && dWEN[sup_r];
`endif
      default: alive_s = 1'b0;
    endcase
  end

  assign acc_s = alive_s && (ramstate == ACCESS);

  // Next-state, grant and round-robin pointer logic.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    dptr_s  = dptr_r;
    iptr_s  = iptr_r;
`ifdef MULTI_BUS_COHERENCE_EN
    sup_s   = sup_r;
`endif
    case (state_r)
      IDLE: begin
        if ((|dreq_s) || (|iREN)) state_s = ARB;
        else                      state_s = IDLE;
      end
      ARB: begin
        if (pick_data_s) begin
          grant_s = didx_s;
          if (dWEN[didx_s]) state_s = RAMWR;
`ifdef MULTI_BUS_COHERENCE_EN
          // A single cache has nobody to snoop, so it reads RAM directly.
          else if ((CPUS > 1) && cctrans[didx_s]) state_s = SNOOP;
`endif
          else state_s = RAMRD;
        end else if (ivalid_s) begin
          grant_s = iidx_s;
          state_s = IFETCH;
        end else begin
          state_s = IDLE;
        end
      end
`ifdef MULTI_BUS_COHERENCE_EN
      SNOOP: begin
        if (!alive_s) state_s = IDLE;
        else          state_s = SNRESP;
      end
      SNRESP: begin
        if (!alive_s) begin
          state_s = IDLE;
        end else if (sup_valid_s) begin
          sup_s   = sup_idx_s;
          state_s = C2C;
        end else begin
          state_s = RAMRD;
        end
      end
      C2C: begin
        if (!alive_s || acc_s) state_s = IDLE;
        else                   state_s = C2C;
        if (acc_s) dptr_s = grant_r;
        else       dptr_s = dptr_r;
      end
`endif
      RAMRD, RAMWR: begin
        if (!alive_s || acc_s) state_s = IDLE;
        else                   state_s = state_r;
        if (acc_s) dptr_s = grant_r;
        else       dptr_s = dptr_r;
      end
      IFETCH: begin
        if (!alive_s || acc_s) state_s = IDLE;
        else                   state_s = IFETCH;
        if (acc_s) iptr_s = grant_r;
        else       iptr_s = iptr_r;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, grant and pointers; pointers start at CPUS-1 so CPU0 wins first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      grant_r <= '0;
      dptr_r  <= IW'(CPUS - 1);
      iptr_r  <= IW'(CPUS - 1);
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      dptr_r  <= dptr_s;
      iptr_r  <= iptr_s;
    end
  end

  // Output decode from the registered state; RAM is only driven while the request is alive.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int k = 0; k < CPUS; k++) begin
      iload[k]       = '0;
      dload[k]       = '0;
      ccsnoopaddr[k] = '0;
    end
    case (state_r)
      RAMRD: begin
        ramREN         = alive_s;
        ramaddr        = alive_s ? daddr[grant_r] : '0;
        dwait[grant_r] = !acc_s;
        dload[grant_r] = acc_s ? ramload : '0;
      end
      RAMWR: begin
        ramWEN         = alive_s;
        ramaddr        = alive_s ? daddr[grant_r] : '0;
        ramstore       = alive_s ? dstore[grant_r] : '0;
        dwait[grant_r] = !acc_s;
      end
      IFETCH: begin
        ramREN         = alive_s;
        ramaddr        = alive_s ? iaddr[grant_r] : '0;
        iwait[grant_r] = !acc_s;
        iload[grant_r] = acc_s ? ramload : '0;
      end
`ifdef MULTI_BUS_COHERENCE_EN
      SNOOP, SNRESP: begin
        for (int k = 0; k < CPUS; k++) begin
          ccwait[k]      = alive_s && (k != int'(grant_r));
          ccinv[k]       = ccwait[k] && ccwrite[grant_r];
          ccsnoopaddr[k] = ccwait[k] ? daddr[grant_r] : '0;
        end
      end
      C2C: begin
        // The supplier's dirty line is written back and forwarded in the same beat.
        ramWEN         = alive_s;
        ramaddr        = alive_s ? daddr[sup_r] : '0;
        ramstore       = alive_s ? dstore[sup_r] : '0;
        dload[grant_r] = alive_s ? dstore[sup_r] : '0;
        dwait[grant_r] = !acc_s;
        dwait[sup_r]   = !acc_s;
      end
`endif
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule
